// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and helpers for the uart_rx_gen receiver:
//                FSM state encoding, parity-type constants and the per-bit
//                sample-point calculation derived from the prescale value.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP1  = 3'd4,
        ST_STOP2  = 3'd5,
        ST_DONE   = 3'd6
    } rx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Counter values of interest within one bit period.
    typedef struct packed {
        logic [15:0] s0;    // first majority sample
        logic [15:0] s1;    // second majority sample
        logic [15:0] s2;    // third majority sample
        logic [15:0] vld;   // voted bit presented to the FSM
        logic [15:0] last;  // final count of the bit period
    } sample_pts_t;

    function automatic sample_pts_t sample_points(input logic [15:0] prescale);
        sample_pts_t p;
        logic [15:0] half;
        half   = prescale >> 1;
        p.s0   = half - 16'd2;
        p.s1   = half - 16'd1;
        p.s2   = half;
        p.vld  = half + 16'd1;
        p.last = prescale - 16'd1;
        return p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_gen_if
//  Description : Bundle of serial line, frame configuration and the
//                valid/ready output holding-register signals of uart_rx_gen.
//                master : receiver side (drives the received word and flags)
//                slave  : line driver / consumer side
//  Revision    : 1.0  initial release
// ============================================================================
interface uart_rx_gen_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
);
    logic                  rx_in;
    logic [PRESCALE_W-1:0] prescale;
    logic                  par_en;
    logic                  par_typ;
    logic                  stop2;
    logic                  rx_ready;
    logic                  data_valid;
    logic [DATA_WIDTH-1:0] p_data;
    logic                  par_err;
    logic                  stp_err;
    logic                  ovr_err;
    logic                  break_det;

    modport master (
        input  rx_in, prescale, par_en, par_typ, stop2, rx_ready,
        output data_valid, p_data, par_err, stp_err, ovr_err, break_det
    );

    modport slave (
        output rx_in, prescale, par_en, par_typ, stop2, rx_ready,
        input  data_valid, p_data, par_err, stp_err, ovr_err, break_det
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_sampler.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_sampler
//  Description : Per-bit edge counter with 3-sample majority vote.
//  Ports       : clk_i, rst_ni     clock, async active-low reset
//                rx_s_i            synchronised serial line
//                clear_i           hold counter at 0 (receiver idle)
//                prescale_i        oversampling ratio for the current frame
//                bit_valid_o       one-cycle strobe, bit_o holds voted value
//                wrap_o            counter is at its last count of the bit
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx_sampler #(
    parameter int PRESCALE_W = 6
) (
    input  wire logic                  clk_i,
    input  wire logic                  rst_ni,
    input  wire logic                  rx_s_i,
    input  wire logic                  clear_i,
    input  wire logic [PRESCALE_W-1:0] prescale_i,
    output logic                       bit_valid_o,
    output logic                       bit_o,
    output logic                       wrap_o
);
    import uart_pkg::*;

    logic [PRESCALE_W-1:0] cnt_q, cnt_d;
    logic [2:0]            smp_q, smp_d;
    logic [15:0]           cnt_ext;
    sample_pts_t           pts;

    assign pts     = sample_points(16'(prescale_i));
    assign cnt_ext = 16'(cnt_q);
    assign wrap_o  = (cnt_ext == pts.last);

    always_comb begin
        cnt_d = cnt_q;
        smp_d = smp_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (wrap_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        if (cnt_ext == pts.s0) smp_d[0] = rx_s_i;
        if (cnt_ext == pts.s1) smp_d[1] = rx_s_i;
        if (cnt_ext == pts.s2) smp_d[2] = rx_s_i;
    end

    // All three samples are registered by the vld count, so the vote is a
    // pure function of stored samples.
    assign bit_valid_o = !clear_i && (cnt_ext == pts.vld);
    assign bit_o       = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            smp_q <= 3'b111;
        end else begin
            cnt_q <= cnt_d;
            smp_q <= smp_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_gen.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_gen
//  Description : Oversampling UART receiver with majority-vote bit recovery,
//                optional parity, 1/2 stop bits, break detection and a
//                valid/ready holding register with overrun reporting.
//  Ports       : clk_i   receiver (oversampling) clock
//                rst_ni  asynchronous active-low reset
//                bus     uart_rx_gen_if.master: rx_in, prescale, par_en,
//                        par_typ, stop2, rx_ready in; data_valid, p_data,
//                        par_err, stp_err, ovr_err, break_det out
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input wire logic      clk_i,
    input wire logic      rst_ni,
    uart_rx_gen_if.master bus
);
    import uart_pkg::*;

    localparam int IDX_W = $clog2(DATA_WIDTH + 1);

    rx_state_e             state_q, state_d;
    logic [1:0]            sync_q;
    logic                  rx_prev_q;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic                  par_en_q, par_en_d, par_typ_q, par_typ_d, stop2_q, stop2_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  fpar_q, fpar_d, fstp_q, fstp_d;   // flags of frame in flight
    logic                  nz_q, nz_d;                       // any data/parity bit was 1
    logic                  brk_q, brk_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  par_err_q, par_err_d, stp_err_q, stp_err_d;
    logic                  ovr_q, ovr_d, brk_det_q, brk_det_d;

    logic rx_s, bit_valid, bit_v, wrap;

    assign rx_s = sync_q[1];

    uart_rx_sampler #(.PRESCALE_W(PRESCALE_W)) u_sampler (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .rx_s_i      (rx_s),
        .clear_i     (state_q == ST_IDLE),
        .prescale_i  (prescale_q),
        .bit_valid_o (bit_valid),
        .bit_o       (bit_v),
        .wrap_o      (wrap)
    );

    always_comb begin
        state_d    = state_q;
        prescale_d = prescale_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        stop2_d    = stop2_q;
        shift_d    = shift_q;
        idx_d      = idx_q;
        fpar_d     = fpar_q;
        fstp_d     = fstp_q;
        nz_d       = nz_q;
        brk_d      = brk_q;
        valid_d    = valid_q;
        data_d     = data_q;
        par_err_d  = par_err_q;
        stp_err_d  = stp_err_q;
        ovr_d      = 1'b0;
        brk_det_d  = 1'b0;

        if (valid_q && bus.rx_ready) valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Edge-qualified start: after a break the line must return
                // high before a new start can be armed.
                if (rx_prev_q && !rx_s) begin
                    state_d    = ST_START;
                    prescale_d = bus.prescale;
                    par_en_d   = bus.par_en;
                    par_typ_d  = bus.par_typ;
                    stop2_d    = bus.stop2;
                    idx_d      = '0;
                    fpar_d     = 1'b0;
                    fstp_d     = 1'b0;
                    nz_d       = 1'b0;
                    brk_d      = 1'b0;
                end
            end
            ST_START: begin
                if (bit_valid && bit_v) state_d = ST_IDLE;
                else if (wrap)          state_d = ST_DATA;
            end
            ST_DATA: begin
                if (bit_valid) begin
                    shift_d = {bit_v, shift_q[DATA_WIDTH-1:1]};
                    idx_d   = idx_q + 1'b1;
                    nz_d    = nz_q | bit_v;
                end else if (wrap && (idx_q == IDX_W'(DATA_WIDTH))) begin
                    state_d = par_en_q ? ST_PARITY : ST_STOP1;
                end
            end
            ST_PARITY: begin
                if (bit_valid) begin
                    fpar_d = bit_v ^ (^shift_q) ^ (par_typ_q == PAR_ODD);
                    nz_d   = nz_q | bit_v;
                end else if (wrap) begin
                    state_d = ST_STOP1;
                end
            end
            ST_STOP1: begin
                // Leave right after the vote; the counter keeps running so a
                // second stop bit is sampled in the following period.
                if (bit_valid) begin
                    if (!bit_v) fstp_d = 1'b1;
                    if (!bit_v && !nz_q) begin
                        brk_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = stop2_q ? ST_STOP2 : ST_DONE;
                    end
                end
            end
            ST_STOP2: begin
                if (bit_valid) begin
                    if (!bit_v) fstp_d = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                if (brk_q) begin
                    brk_det_d = 1'b1;
                end else if (!valid_q || bus.rx_ready) begin
                    valid_d   = 1'b1;
                    data_d    = shift_q;
                    par_err_d = fpar_q;
                    stp_err_d = fstp_q;
                end else begin
                    ovr_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            sync_q     <= 2'b11;
            rx_prev_q  <= 1'b1;
            prescale_q <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= PAR_EVEN;
            stop2_q    <= 1'b0;
            shift_q    <= '0;
            idx_q      <= '0;
            fpar_q     <= 1'b0;
            fstp_q     <= 1'b0;
            nz_q       <= 1'b0;
            brk_q      <= 1'b0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            par_err_q  <= 1'b0;
            stp_err_q  <= 1'b0;
            ovr_q      <= 1'b0;
            brk_det_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= {sync_q[0], bus.rx_in};
            rx_prev_q  <= rx_s;
            prescale_q <= prescale_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
            stop2_q    <= stop2_d;
            shift_q    <= shift_d;
            idx_q      <= idx_d;
            fpar_q     <= fpar_d;
            fstp_q     <= fstp_d;
            nz_q       <= nz_d;
            brk_q      <= brk_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            par_err_q  <= par_err_d;
            stp_err_q  <= stp_err_d;
            ovr_q      <= ovr_d;
            brk_det_q  <= brk_det_d;
        end
    end

    assign bus.data_valid = valid_q;
    assign bus.p_data     = data_q;
    assign bus.par_err    = par_err_q;
    assign bus.stp_err    = stp_err_q;
    assign bus.ovr_err    = ovr_q;
    assign bus.break_det  = brk_det_q;

endmodule
`default_nettype wire
